// File: rtl/vga_scan_out.sv
// VGA raster generator that scans a shadow copy of a flat image matrix out one pixel per clock, upscaled by SCALE.
// Optional build macro VGA_TEST_PATTERN_EN: show a checkerboard until the first frame has been captured.
module vga_scan_out #(
    parameter int IMAGE_BITS = 8,
    parameter int MATRIX_N   = 120,
    parameter int MATRIX_M   = 120,
    parameter int SCALE      = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FLAT_WIDE  = IMAGE_BITS * MATRIX_N * MATRIX_M
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [FLAT_WIDE-1:0]  FrameMat,
    input  logic                  ReqIn,
    output logic                  AckIn,
    output logic                  HSync,
    output logic                  VSync,
    output logic                  Active,
    output logic [IMAGE_BITS-1:0] PixelOut,
    output logic                  FrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PIX_NUM = MATRIX_N * MATRIX_M;
    localparam int AW      = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
    localparam int IMG_W   = MATRIX_N * SCALE;
    localparam int IMG_H   = MATRIX_M * SCALE;

    logic [HW-1:0]         h_cnt_reg;
    logic [VW-1:0]         v_cnt_reg;
    logic [IMAGE_BITS-1:0] shadow_reg [PIX_NUM];

    logic [31:0]           h_int;
    logic [31:0]           v_int;
    logic [31:0]           col;
    logic [31:0]           row;
    logic [31:0]           pix_idx;
    logic                  h_last;
    logic                  v_last;
    logic                  capture;
    logic                  in_image;
    logic [IMAGE_BITS-1:0] pixel_next;

    assign h_int    = 32'(h_cnt_reg);
    assign v_int    = 32'(v_cnt_reg);
    assign col      = h_int / SCALE;
    assign row      = v_int / SCALE;
    assign pix_idx  = row * MATRIX_N + col;
    assign h_last   = (h_int == H_TOTAL - 1);
    assign v_last   = (v_int == V_TOTAL - 1);
    assign capture  = h_last && v_last && ReqIn;
    assign in_image = (h_int < IMG_W) && (v_int < IMG_H);

    // Capturing only at the last cycle of the frame keeps every displayed frame whole.
    generate
        for (genvar gi = 0; gi < PIX_NUM; gi++) begin : g_shadow
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    shadow_reg[gi] <= '0;
                end else if (capture) begin
                    shadow_reg[gi] <= FrameMat[gi*IMAGE_BITS +: IMAGE_BITS];
                end
            end
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    logic loaded_reg;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            loaded_reg <= 1'b0;
        end else if (capture) begin
            loaded_reg <= 1'b1;
        end
    end

    always_comb begin
        pixel_next = '0;
        if (in_image) begin
            if (loaded_reg) begin
                pixel_next = shadow_reg[pix_idx[AW-1:0]];
            end else if (row[0] ^ col[0]) begin
                pixel_next = '1;
            end
        end
    end
`else
    always_comb begin
        pixel_next = '0;
        if (in_image) begin
            pixel_next = shadow_reg[pix_idx[AW-1:0]];
        end
    end
`endif

    // Every output decodes the current counters, so all share one clock of latency.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            h_cnt_reg  <= '0;
            v_cnt_reg  <= '0;
            HSync      <= 1'b1;
            VSync      <= 1'b1;
            Active     <= 1'b0;
            PixelOut   <= '0;
            AckIn      <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            if (h_last) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 1'b1;
            end
            HSync      <= !((h_int >= H_ACTIVE + H_FP) && (h_int < H_ACTIVE + H_FP + H_SYNC));
            VSync      <= !((v_int >= V_ACTIVE + V_FP) && (v_int < V_ACTIVE + V_FP + V_SYNC));
            Active     <= (h_int < H_ACTIVE) && (v_int < V_ACTIVE);
            PixelOut   <= pixel_next;
            AckIn      <= capture;
            FrameStart <= (h_int == 0) && (v_int == 0);
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out on a shrunken raster (20x13 clocks/lines, 4x3 image, scale 2).
module tb_vga_scan_out;

    localparam int IB = 8;
    localparam int MN = 4;
    localparam int MM = 3;
    localparam int SC = 2;
    localparam int HT = 20;
    localparam int VT = 13;
    localparam int FRAME = HT * VT;
    localparam int FW = IB * MN * MM;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [7:0] PAT = 8'hFF;
`else
    localparam logic [7:0] PAT = 8'h00;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [FW-1:0] FrameMat = '0;
    logic          ReqIn = 1'b0;
    logic          AckIn;
    logic          HSync;
    logic          VSync;
    logic          Active;
    logic [IB-1:0] PixelOut;
    logic          FrameStart;

    int errors = 0;
    int checks = 0;
    int n = 0;

    vga_scan_out #(
        .IMAGE_BITS(IB), .MATRIX_N(MN), .MATRIX_M(MM), .SCALE(SC),
        .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .FrameMat(FrameMat), .ReqIn(ReqIn), .AckIn(AckIn),
        .HSync(HSync), .VSync(VSync), .Active(Active), .PixelOut(PixelOut), .FrameStart(FrameStart)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        n++;
    endtask

    // Advance until the outputs reflect counter position (h,v); outputs lag the counters by one clock.
    task automatic goto(input int h, input int v);
        bit hit = 1'b0;
        for (int k = 0; k < 2 * FRAME && !hit; k++) begin
            tick();
            if (((n - 1) % FRAME) == v * HT + h) hit = 1'b1;
        end
        if (!hit) begin
            errors++;
            $display("FAIL goto observed=timeout expected=(%0d,%0d)", h, v);
        end
    endtask

    task automatic set_pix(input int r, input int c, input logic [7:0] val);
        FrameMat[(r*MN + c)*IB +: IB] = val;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("rst_hsync", HSync, 1);
        check("rst_vsync", VSync, 1);
        check("rst_active", Active, 0);
        check("rst_pixel", PixelOut, 0);
        check("rst_ack", AckIn, 0);
        check("rst_fstart", FrameStart, 0);

        @(negedge Clk);
        Reset = 1'b1;
        n = 0;

        goto(0, 0);  check("f0_fstart", FrameStart, 1); check("f0_pix00", PixelOut, 0);
        goto(1, 0);  check("f0_fstart_end", FrameStart, 0);
        goto(2, 0);  check("f0_pix_c1", PixelOut, PAT);
        goto(11, 0); check("act_edge_in", Active, 1);
        goto(12, 0); check("act_edge_out", Active, 0);
        goto(13, 0); check("hs_before", HSync, 1);
        goto(14, 0); check("hs_first", HSync, 0);
        goto(16, 0); check("hs_last", HSync, 0);
        goto(17, 0); check("hs_after", HSync, 1);
        goto(0, 2);  check("f0_pix_r1", PixelOut, PAT);
        goto(11, 7); check("act_corner", Active, 1);
        goto(0, 8);  check("act_vblank", Active, 0);
        goto(19, 8); check("vs_before", VSync, 1);
        goto(0, 9);  check("vs_first", VSync, 0);
        goto(19, 10); check("vs_last", VSync, 0);
        goto(0, 11); check("vs_after", VSync, 1);

        // Request raised mid-frame; capture must wait for the frame boundary.
        goto(5, 3);
        set_pix(0, 0, 8'h5A);
        set_pix(0, 1, 8'hC3);
        set_pix(2, 3, 8'hFF);
        ReqIn = 1'b1;
        goto(18, 12); check("ack_early", AckIn, 0);
        goto(19, 12); check("ack_pulse", AckIn, 1);
        goto(0, 0);
        check("ack_end", AckIn, 0);
        check("new_pix00", PixelOut, 8'h5A);
        check("new_fstart", FrameStart, 1);
        goto(1, 0);  check("new_pix00_h1", PixelOut, 8'h5A);
        goto(2, 0);  check("new_pix01", PixelOut, 8'hC3);
        goto(3, 0);  check("new_pix01_h3", PixelOut, 8'hC3);
        goto(5, 0);  ReqIn = 1'b0;
        goto(0, 1);  check("new_pix00_v1", PixelOut, 8'h5A);
        goto(4, 1);  check("new_pix02", PixelOut, 8'h00);
        goto(6, 5);  check("last_pix_a", PixelOut, 8'hFF);
        goto(7, 5);  check("last_pix_b", PixelOut, 8'hFF);
        goto(8, 5);  check("right_of_img", PixelOut, 8'h00);
        goto(7, 6);  check("below_img", PixelOut, 8'h00);

        // Short pulse that is gone before the boundary must not load anything.
        goto(0, 8);
        set_pix(0, 0, 8'h11);
        ReqIn = 1'b1;
        repeat (10) tick();
        ReqIn = 1'b0;
        goto(19, 12); check("no_ack", AckIn, 0);
        goto(0, 0);  check("kept_pix00", PixelOut, 8'h5A);
        goto(2, 0);  check("kept_pix01", PixelOut, 8'hC3);
        check("kept_active", Active, 1);

        // Asynchronous reset takes effect without a clock edge.
        Reset = 1'b0;
        #1;
        check("arst_pixel", PixelOut, 0);
        check("arst_active", Active, 0);
        check("arst_hsync", HSync, 1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        n = 0;
        goto(0, 0);  check("rr_fstart", FrameStart, 1); check("rr_pix00", PixelOut, 0);
        goto(2, 0);  check("rr_pix01", PixelOut, PAT);
        goto(14, 0); check("rr_hsync", HSync, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
